perf_stats: RTL

- Run-time statistics unit directly upstream of the board LED/display stage.
- Counts CPU clock cycles, conditional branches, taken conditional branches and unconditional jumps, and tracks the current PC.
- Uses the 3-bit display selector from the board switches to pick one statistic and presents it as a registered 32-bit value to the display stage.
- Freezes all statistics when the CPU halts, so the final values stay readable.

---
 rtl/perf_stats.sv | 83 ++++++++
 1 files changed

// File: rtl/perf_stats.sv
// Run-time statistics: cycle/branch/jump counters plus PC snapshot,
// one statistic selected by switches and registered for the display.
module perf_stats #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            halt,
  input  logic [PC_W-1:0] pc_in,
  input  logic            is_branch,
  input  logic            branch_taken,
  input  logic            is_jump,
  input  logic [2:0]      sel,
  output logic [31:0]     stat_value,
  output logic            halted
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] tk_cnt;
  logic [CNT_W-1:0] jmp_cnt;
  logic [PC_W-1:0]  pc_q;
  logic [31:0]      next_val;

  // Saturating step: a full counter holds rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
      br_cnt  <= '0;
      tk_cnt  <= '0;
      jmp_cnt <= '0;
      pc_q    <= '0;
    end else if (clear) begin
      cyc_cnt <= '0;
      br_cnt  <= '0;
      tk_cnt  <= '0;
      jmp_cnt <= '0;
      pc_q    <= '0;
    end else if (!halt) begin
      cyc_cnt <= sat_inc(cyc_cnt);
      pc_q    <= pc_in;
      if (is_branch)
        br_cnt <= sat_inc(br_cnt);
      if (is_branch && branch_taken)
        tk_cnt <= sat_inc(tk_cnt);
      if (is_jump)
        jmp_cnt <= sat_inc(jmp_cnt);
    end
  end

  always_comb begin
    next_val = '0;
    unique case (sel)
      3'b001:  next_val = 32'(pc_q);
      3'b010:  next_val = 32'(cyc_cnt);
      3'b011:  next_val = 32'(br_cnt);
      3'b100:  next_val = 32'(tk_cnt);
      3'b101:  next_val = 32'(jmp_cnt);
      default: next_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_value <= '0;
      halted     <= 1'b0;
    end else begin
      stat_value <= next_val;
      halted     <= halt;
    end
  end

endmodule
